// File: rtl/systolic_sequencer.sv
// systolic_sequencer -- job sequencer for an ARRAY_SIZE x ARRAY_SIZE systolic array.
//
// A job is accepted on start&ready. The sequencer then writes ARRAY_SIZE weight
// rows (w_load/w_row_sel), streams cfg_num_vec input vectors (in_pop follows
// in_valid, stalls leave gaps), waits until every popped vector has emerged as
// a psum row (psum_valid = in_pop delayed PIPE_LAT cycles), and pulses done.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   start / ready                    job handshake
//   cfg_in_width, cfg_weight_width   operand widths (1,2,4,8; others -> 8)
//   cfg_s_in, cfg_s_weight           operand signedness
//   cfg_num_vec                      vectors in the job
//   in_valid / in_pop                upstream vector handshake
//   w_load, w_row_sel                weight row write strobe and row index
//   in_width, weight_width, s_in, s_weight   latched job config to the array
//   psum_valid, busy, done           status
//   cycle_cnt, stall_cnt             perf counters (only with SYSTOLIC_SEQ_PERF_EN)
//
// Optional feature macro: SYSTOLIC_SEQ_PERF_EN adds the perf counter outputs.
module systolic_sequencer #(
  parameter int ARRAY_SIZE     = 8,
  parameter int LOG_ARRAY_SIZE = 3,
  parameter int PIPE_LAT       = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      ready,
  input  logic [3:0]                cfg_in_width,
  input  logic [3:0]                cfg_weight_width,
  input  logic                      cfg_s_in,
  input  logic                      cfg_s_weight,
  input  logic [15:0]               cfg_num_vec,
  input  logic                      in_valid,
  output logic                      in_pop,
  output logic                      w_load,
  output logic [LOG_ARRAY_SIZE-1:0] w_row_sel,
  output logic [3:0]                in_width,
  output logic [3:0]                weight_width,
  output logic                      s_in,
  output logic                      s_weight,
  output logic                      psum_valid,
  output logic                      busy,
  output logic                      done
`ifdef SYSTOLIC_SEQ_PERF_EN
  ,
  output logic [31:0]               cycle_cnt,
  output logic [31:0]               stall_cnt
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_STREAM, S_DRAIN, S_DONE} state_t;

  localparam logic [LOG_ARRAY_SIZE-1:0] ROW_LAST = LOG_ARRAY_SIZE'(ARRAY_SIZE - 1);

  state_t                      state_q;
  logic                        ready_q, busy_q, done_q, w_load_q;
  logic [LOG_ARRAY_SIZE-1:0]   row_q;
  logic [15:0]                 num_vec_q, issued_q, issued_d;
  logic [3:0]                  in_width_q, weight_width_q;
  logic                        s_in_q, s_weight_q;
  logic [PIPE_LAT-1:0]         dl_q, dl_d;
  logic                        accept, last_pop;

  // Non-power-of-two or out-of-range widths fall back to full 8-bit precision.
  function automatic logic [3:0] legal_w(input logic [3:0] w);
    case (w)
      4'd1, 4'd2, 4'd4, 4'd8: legal_w = w;
      default:                legal_w = 4'd8;
    endcase
  endfunction

  assign accept   = (state_q == S_IDLE) && start;
  assign in_pop   = (state_q == S_STREAM) && in_valid;
  assign issued_d = issued_q + 16'd1;
  assign last_pop = in_pop && (issued_d == num_vec_q);

  // Delay line: bit k holds a pop made k+1 cycles ago; the top bit is the psum row.
  assign dl_d       = (dl_q << 1) | PIPE_LAT'(in_pop);
  assign psum_valid = dl_q[PIPE_LAT-1];

  always_ff @(posedge clk) begin
    if (reset) dl_q <= '0;
    else       dl_q <= dl_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      ready_q        <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      w_load_q       <= 1'b0;
      row_q          <= '0;
      num_vec_q      <= '0;
      issued_q       <= '0;
      in_width_q     <= 4'd8;
      weight_width_q <= 4'd8;
      s_in_q         <= 1'b0;
      s_weight_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            in_width_q     <= legal_w(cfg_in_width);
            weight_width_q <= legal_w(cfg_weight_width);
            s_in_q         <= cfg_s_in;
            s_weight_q     <= cfg_s_weight;
            num_vec_q      <= cfg_num_vec;
            issued_q       <= '0;
            ready_q        <= 1'b0;
            busy_q         <= 1'b1;
            row_q          <= '0;
            if (cfg_num_vec == 16'd0) begin
              // Empty job: skip weight load and streaming entirely.
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q  <= S_LOAD_W;
              w_load_q <= 1'b1;
            end
          end
        end
        S_LOAD_W: begin
          if (row_q == ROW_LAST) begin
            state_q  <= S_STREAM;
            w_load_q <= 1'b0;
            row_q    <= '0;
          end else begin
            row_q <= row_q + 1'b1;
          end
        end
        S_STREAM: begin
          if (in_pop) issued_q <= issued_d;
          if (last_pop) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          // Whole delay line empty: the last psum row has already been presented.
          if (dl_q == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q  <= S_IDLE;
          done_q   <= 1'b0;
          busy_q   <= 1'b0;
          ready_q  <= 1'b1;
          w_load_q <= 1'b0;
          row_q    <= '0;
        end
      endcase
    end
  end

  assign ready        = ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign w_load       = w_load_q;
  assign w_row_sel    = row_q;
  assign in_width     = in_width_q;
  assign weight_width = weight_width_q;
  assign s_in         = s_in_q;
  assign s_weight     = s_weight_q;

`ifdef SYSTOLIC_SEQ_PERF_EN
  logic [31:0] cycle_cnt_q, stall_cnt_q;

  // Saturating counters; cleared on accept so they report the most recent job.
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (busy_q && (cycle_cnt_q != '1))
        cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if ((state_q == S_STREAM) && !in_valid && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule
